// File: rtl/target_rx_pkg.sv
// Shared definitions for the target HDR-DDR receiver: mode codes, CRC token
// and per-mode field lengths. Mode codes match the target serializer.
package target_rx_pkg;

  localparam logic [2:0] MODE_PREAMBLE  = 3'b000;
  localparam logic [2:0] MODE_BYTE      = 3'b011;
  localparam logic [2:0] MODE_PAR_CHECK = 3'b110;
  localparam logic [2:0] MODE_CRC_TOKEN = 3'b010;
  localparam logic [2:0] MODE_CRC_VALUE = 3'b111;

  localparam logic [3:0] CRC_TOKEN = 4'b1100;

  localparam int unsigned LEN_PREAMBLE  = 1;
  localparam int unsigned LEN_BYTE      = 8;
  localparam int unsigned LEN_PAR_CHECK = 2;
  localparam int unsigned LEN_CRC_TOKEN = 4;
  localparam int unsigned LEN_CRC_VALUE = 5;

  typedef struct packed {
    logic       active;
    logic [2:0] last;
  } field_t;

  // Index of the final bit of the field for a mode; inactive for idle codes.
  function automatic field_t field_info(input logic [2:0] mode);
    field_t f;
    f.active = 1'b1;
    f.last   = 3'd0;
    case (mode)
      MODE_PREAMBLE:  f.last = 3'(LEN_PREAMBLE - 1);
      MODE_BYTE:      f.last = 3'(LEN_BYTE - 1);
      MODE_PAR_CHECK: f.last = 3'(LEN_PAR_CHECK - 1);
      MODE_CRC_TOKEN: f.last = 3'(LEN_CRC_TOKEN - 1);
      MODE_CRC_VALUE: f.last = 3'(LEN_CRC_VALUE - 1);
      default:        f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/target_rx_if.sv
// Signal bundle between the target receiver and its neighbours (SCL generator,
// SDA handler, DDR CCC FSM, register file, CRC block).
interface target_rx_if;
  import target_rx_pkg::*;

  logic       i_sclgen_scl_pos_edge;
  logic       i_sclgen_scl_neg_edge;
  logic       i_sdahnd_tgt_serial_data;
  logic       i_ddrccc_rx_en;
  logic [2:0] i_ddrccc_rx_mode;
  logic [4:0] i_crc_crc_value;
  logic       o_ddrccc_rx_mode_done;
  logic       o_ddrccc_pre;
  logic       o_ddrccc_error;
  logic [7:0] o_regf_rx_parallel_data;
  logic       o_regf_wr_en;
  logic       o_crc_en;
  logic [7:0] o_crc_parallel_data;

  modport slave (
    input  i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_sdahnd_tgt_serial_data,
           i_ddrccc_rx_en, i_ddrccc_rx_mode, i_crc_crc_value,
    output o_ddrccc_rx_mode_done, o_ddrccc_pre, o_ddrccc_error,
           o_regf_rx_parallel_data, o_regf_wr_en, o_crc_en, o_crc_parallel_data
  );

  modport master (
    output i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_sdahnd_tgt_serial_data,
           i_ddrccc_rx_en, i_ddrccc_rx_mode, i_crc_crc_value,
    input  o_ddrccc_rx_mode_done, o_ddrccc_pre, o_ddrccc_error,
           o_regf_rx_parallel_data, o_regf_wr_en, o_crc_en, o_crc_parallel_data
  );

endinterface

// File: rtl/target_rx_parity.sv
// Expected HDR-DDR parity for a 16-bit data word: P1 over the odd bits,
// P0 over the even bits inverted. Shared with the transmitter.
module target_rx_parity (
  input  logic [15:0] word_i,
  output logic [1:0]  parity_o
);

  assign parity_o[1] = ^(word_i & 16'hAAAA);
  assign parity_o[0] = ~^(word_i & 16'h5555);

endmodule

// File: rtl/target_rx.sv
// Target HDR-DDR receiver: samples SDA on both SCL edges and checks fields.
// Define TARGET_RX_CRC_CHECK_EN to enable CRC token/value checks and o_crc_en.
module target_rx
  import target_rx_pkg::*;
(
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  target_rx_if.slave  rx_if
);

`ifdef TARGET_RX_CRC_CHECK_EN
  localparam logic CRC_CHECK_EN = 1'b1;
`else
  localparam logic CRC_CHECK_EN = 1'b0;
`endif

  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  mode_q;
  logic        byte_num_q, byte_num_d;
  logic [15:0] word_q, word_d;
  logic        pre_q, pre_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        crc_en_q, crc_en_d;

  logic        sample;
  logic        sda;
  logic [2:0]  mode;
  field_t      fld;
  logic [2:0]  cnt_eff;
  logic [7:0]  shift_nx;
  logic [1:0]  par_exp;

  assign sample   = rx_if.i_sclgen_scl_pos_edge | rx_if.i_sclgen_scl_neg_edge;
  assign sda      = rx_if.i_sdahnd_tgt_serial_data;
  assign mode     = rx_if.i_ddrccc_rx_mode;
  assign fld      = field_info(mode);
  // A mode change drops any partial field: count from zero in the new mode.
  assign cnt_eff  = (mode != mode_q) ? 3'd0 : cnt_q;
  assign shift_nx = {shift_q, sda};

  target_rx_parity u_parity (
    .word_i   (word_q),
    .parity_o (par_exp)
  );

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    byte_num_d = byte_num_q;
    word_d     = word_q;
    pre_d      = pre_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_d       = 1'b0;
    crc_en_d   = 1'b0;
    if (!rx_if.i_ddrccc_rx_en || !fld.active) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_eff;
      if (mode == MODE_PREAMBLE) byte_num_d = 1'b0;
      if (sample) begin
        shift_d = shift_nx[6:0];
        if (cnt_eff == fld.last) begin
          cnt_d  = 3'd0;
          done_d = 1'b1;
          case (mode)
            MODE_PREAMBLE: pre_d = sda;
            MODE_BYTE: begin
              data_d     = shift_nx;
              wr_d       = 1'b1;
              crc_en_d   = CRC_CHECK_EN;
              byte_num_d = ~byte_num_q;
              if (byte_num_q) word_d[7:0]  = shift_nx;
              else            word_d[15:8] = shift_nx;
            end
            MODE_PAR_CHECK: err_d = (shift_nx[1:0] != par_exp);
            MODE_CRC_TOKEN: err_d = CRC_CHECK_EN & (shift_nx[3:0] != CRC_TOKEN);
            MODE_CRC_VALUE: err_d = CRC_CHECK_EN & (shift_nx[4:0] != rx_if.i_crc_crc_value);
            default: ;
          endcase
        end else begin
          cnt_d = cnt_eff + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      mode_q     <= '0;
      byte_num_q <= 1'b0;
      word_q     <= '0;
      pre_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      crc_en_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mode_q     <= mode;
      byte_num_q <= byte_num_d;
      word_q     <= word_d;
      pre_q      <= pre_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      crc_en_q   <= crc_en_d;
    end
  end

  assign rx_if.o_ddrccc_rx_mode_done   = done_q;
  assign rx_if.o_ddrccc_pre            = pre_q;
  assign rx_if.o_ddrccc_error          = err_q;
  assign rx_if.o_regf_rx_parallel_data = data_q;
  assign rx_if.o_regf_wr_en            = wr_q;
  assign rx_if.o_crc_en                = crc_en_q;
  assign rx_if.o_crc_parallel_data     = data_q;

endmodule

// File: tb/tb_target_rx.sv
// Scoreboard bench for target_rx: stimulus tasks push expected field results,
// a monitor pops and compares them whenever the receiver pulses an output.
module tb_target_rx;

`ifdef TARGET_RX_CRC_CHECK_EN
  localparam bit CRCEN = 1'b1;
`else
  localparam bit CRCEN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic       done;
    logic       err;
    logic       wr;
    logic       crcen;
    logic [7:0] data;
    logic       pre;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // reference model state
  logic       m_pre;
  logic [7:0] m_data;
  logic [7:0] m_hi, m_lo;
  bit         m_second;

  target_rx_if bus();

  target_rx dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .rx_if     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] par_model(input logic [15:0] w);
    logic p1, p0;
    p1 = 1'b0;
    p0 = 1'b1;
    for (int i = 15; i >= 1; i -= 2) p1 ^= w[i];
    for (int i = 14; i >= 0; i -= 2) p0 ^= w[i];
    return {p1, p0};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n && (bus.o_ddrccc_rx_mode_done || bus.o_ddrccc_error ||
                  bus.o_regf_wr_en || bus.o_crc_en)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {28'd0, bus.o_ddrccc_rx_mode_done, bus.o_ddrccc_error,
            bus.o_regf_wr_en, bus.o_crc_en}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cycle",    cyc, e.cyc);
        chk("done",     bus.o_ddrccc_rx_mode_done, e.done);
        chk("error",    bus.o_ddrccc_error, e.err);
        chk("wr_en",    bus.o_regf_wr_en, e.wr);
        chk("crc_en",   bus.o_crc_en, e.crcen);
        chk("rx_data",  bus.o_regf_rx_parallel_data, e.data);
        chk("crc_data", bus.o_crc_parallel_data, e.data);
        chk("pre",      bus.o_ddrccc_pre, e.pre);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_done"},  bus.o_ddrccc_rx_mode_done, 1'b0);
    chk({tag, "_pre"},   bus.o_ddrccc_pre, 1'b0);
    chk({tag, "_err"},   bus.o_ddrccc_error, 1'b0);
    chk({tag, "_data"},  bus.o_regf_rx_parallel_data, 8'h00);
    chk({tag, "_wr"},    bus.o_regf_wr_en, 1'b0);
    chk({tag, "_crcen"}, bus.o_crc_en, 1'b0);
    chk({tag, "_crcd"},  bus.o_crc_parallel_data, 8'h00);
  endtask

  task automatic model_reset();
    m_pre = 1'b0; m_data = 8'h00; m_hi = 8'h00; m_lo = 8'h00; m_second = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input bit push, input exp_t e);
    int r;
    exp_t ee;
    @(negedge clk);
    bus.i_sdahnd_tgt_serial_data = b;
    r = $urandom_range(0, 2);
    bus.i_sclgen_scl_pos_edge = (r != 1);
    bus.i_sclgen_scl_neg_edge = (r != 0);
    if (push) begin
      ee = e;
      ee.cyc = cyc + 1;
      q.push_back(ee);
    end
    @(negedge clk);
    bus.i_sclgen_scl_pos_edge = 1'b0;
    bus.i_sclgen_scl_neg_edge = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic set_mode(input logic [2:0] m);
    @(negedge clk);
    bus.i_ddrccc_rx_mode = m;
    if (m == 3'b000) m_second = 1'b0;
  endtask

  task automatic send_field(input logic [2:0] m, input logic [7:0] val, input int len, input exp_t e);
    set_mode(m);
    for (int i = len - 1; i >= 0; i--) drive_bit(val[i], i == 0, e);
  endtask

  function automatic exp_t base_exp();
    exp_t e;
    e.cyc = 0; e.done = 1'b1; e.err = 1'b0; e.wr = 1'b0; e.crcen = 1'b0;
    e.data = m_data; e.pre = m_pre;
    return e;
  endfunction

  task automatic send_pre(input logic b);
    exp_t e;
    m_pre = b;
    m_second = 1'b0;
    e = base_exp();
    send_field(3'b000, {7'd0, b}, 1, e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    m_data = b;
    if (m_second) m_lo = b; else m_hi = b;
    m_second = !m_second;
    e = base_exp();
    e.wr = 1'b1;
    e.crcen = CRCEN;
    send_field(3'b011, b, 8, e);
  endtask

  task automatic send_par(input logic [1:0] flip);
    exp_t e;
    e = base_exp();
    e.err = (flip != 2'b00);
    send_field(3'b110, {6'd0, par_model({m_hi, m_lo}) ^ flip}, 2, e);
  endtask

  task automatic send_token(input logic [3:0] t);
    exp_t e;
    e = base_exp();
    e.err = CRCEN && (t != 4'b1100);
    send_field(3'b010, {4'd0, t}, 4, e);
  endtask

  task automatic send_crc(input logic [4:0] c, input logic [4:0] v);
    exp_t e;
    @(negedge clk);
    bus.i_crc_crc_value = c;
    e = base_exp();
    e.err = CRCEN && (v != c);
    send_field(3'b111, {3'd0, v}, 5, e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_sclgen_scl_pos_edge = 1'b0;
    bus.i_sclgen_scl_neg_edge = 1'b0;
    bus.i_sdahnd_tgt_serial_data = 1'b0;
    bus.i_ddrccc_rx_en = 1'b1;
    bus.i_ddrccc_rx_mode = 3'b011;
    bus.i_crc_crc_value = 5'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_zero("idle");

    // directed sequence
    send_pre(1'b1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_par(2'b00);
    send_par(2'b01);
    send_token(4'b1100);
    send_token(4'b1101);
    send_crc(5'h13, 5'b10011);
    send_crc(5'h13, 5'b10010);

    // disabled receiver: strobes ignored, counter cleared
    set_mode(3'b011);
    @(negedge clk);
    bus.i_ddrccc_rx_en = 1'b0;
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, base_exp());
    @(negedge clk);
    bus.i_ddrccc_rx_en = 1'b1;
    send_byte(8'h5A);

    // mid-byte abort, then a fresh word starting at the high byte
    set_mode(3'b011);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, base_exp());
    set_mode(3'b000);
    @(negedge clk);
    send_byte(8'hFF);
    send_par(2'b00);

    // randomized transactions
    for (int n = 0; n < 16; n++) begin
      logic [4:0] c, v;
      logic [3:0] t;
      logic [1:0] f;
      send_pre(1'($urandom_range(0, 1)));
      send_byte(8'($urandom_range(0, 255)));
      send_byte(8'($urandom_range(0, 255)));
      f = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      send_par(f);
      t = ($urandom_range(0, 1) == 0) ? 4'b1100 : 4'($urandom_range(0, 15));
      send_token(t);
      c = 5'($urandom_range(0, 31));
      v = ($urandom_range(0, 1) == 0) ? c : 5'($urandom_range(0, 31));
      send_crc(c, v);
    end

    // reset in the middle of a byte
    set_mode(3'b011);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, base_exp());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h81);
    send_par(2'b00);

    repeat (6) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
